bg_tile_fetcher: RTL

//  Sequential background tile fetcher for the PPU render path. Per start pulse: maps screen pixel + scroll + base-NT select to

---
 rtl/bg_tile_fetcher_pkg.sv | 43 ++++
 rtl/bg_tile_fetcher_scroll_coord_wrap.sv | 51 +++++
 rtl/bg_tile_fetcher.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bg_tile_fetcher_pkg.sv
// Shared definitions for the background tile fetcher.
// Contents: FSM state encoding, nametable mirroring codes, default VRAM
// map constants, screen geometry used by the Y wrap, and the mirroring
// helper that maps logical nametable coordinates to a physical table.
package bg_tile_fetcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NT   = 3'd1,
    ST_AT   = 3'd2,
    ST_PLO  = 3'd3,
    ST_PHI  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0] MIRROR_FOUR   = 2'd0;
  localparam logic [1:0] MIRROR_HORZ   = 2'd1;
  localparam logic [1:0] MIRROR_VERT   = 2'd2;
  localparam logic [1:0] MIRROR_SINGLE = 2'd3;

  localparam logic [15:0] NT_BASE_DEF    = 16'h2000;
  localparam logic [15:0] NT_STRIDE_DEF  = 16'h0400;
  localparam logic [15:0] AT_OFFSET_DEF  = 16'h03C0;
  localparam logic [15:0] PAT_STRIDE_DEF = 16'h1000;

  localparam logic [9:0] SCREEN_H = 10'd240;
  localparam logic [9:0] WRAP_H   = 10'd480;

  // Horizontal mirroring shares tables left/right, vertical shares top/bottom.
  function automatic logic [1:0] phys_nt(input logic [1:0] mirror,
                                         input logic       ny,
                                         input logic       nx);
    logic [1:0] p;
    case (mirror)
      MIRROR_FOUR:   p = {ny, nx};
      MIRROR_HORZ:   p = {ny, 1'b0};
      MIRROR_VERT:   p = {1'b0, nx};
      default:       p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bg_tile_fetcher_scroll_coord_wrap.sv
// Combinational scroll/coordinate reduction.
// Takes a screen pixel, scroll offsets, base nametable select and
// mirroring mode; produces the physical nametable, tile row/column and
// fine offsets within the tile.
//   pixel_row_i/pixel_col_i : screen position (any 9-bit value)
//   scroll_x_i/scroll_y_i   : scroll offsets
//   nt_sel_i                : base nametable (bit0 +256 X, bit1 +240 Y)
//   mirror_i                : mirroring mode
//   p_o, trow_o, tcol_o, fine_x_o, fine_y_o : reduced coordinates
module bg_tile_fetcher_scroll_coord_wrap
  import bg_tile_fetcher_pkg::*;
(
  input  logic [8:0] pixel_row_i,
  input  logic [8:0] pixel_col_i,
  input  logic [7:0] scroll_x_i,
  input  logic [7:0] scroll_y_i,
  input  logic [1:0] nt_sel_i,
  input  logic [1:0] mirror_i,
  output logic [1:0] p_o,
  output logic [4:0] trow_o,
  output logic [4:0] tcol_o,
  output logic [2:0] fine_x_o,
  output logic [2:0] fine_y_o
);

  logic [8:0] ax;
  logic [9:0] ay0;
  logic [9:0] ay1;
  logic [9:0] ay2;
  logic       ny;
  logic [7:0] ly;

  // X space is 512 wide, so a plain 9-bit sum wraps correctly.
  assign ax = pixel_col_i + {1'b0, scroll_x_i} + {nt_sel_i[0], 8'h00};

  // Y space is 480 tall; the sum reaches at most 1006, so two conditional
  // subtractions are enough to bring it into 0..479.
  assign ay0 = {1'b0, pixel_row_i} + {2'b00, scroll_y_i} + (nt_sel_i[1] ? SCREEN_H : 10'd0);
  assign ay1 = (ay0 >= WRAP_H) ? ay0 - WRAP_H : ay0;
  assign ay2 = (ay1 >= WRAP_H) ? ay1 - WRAP_H : ay1;

  assign ny = (ay2 >= SCREEN_H);
  assign ly = ny ? 8'(ay2 - SCREEN_H) : ay2[7:0];

  assign tcol_o   = ax[7:3];
  assign fine_x_o = ax[2:0];
  assign trow_o   = ly[7:3];
  assign fine_y_o = ly[2:0];
  assign p_o      = phys_nt(mirror_i, ny, ax[8]);

endmodule

// File: rtl/bg_tile_fetcher.sv
// Sequential background tile fetcher.
// On a start pulse the tile under (pixel_row, pixel_col) is located using
// scroll, base nametable and mirroring; four VRAM bytes (nametable,
// attribute, pattern low, pattern high) are read over a req/ack port and
// the tile is presented with a one-cycle tile_valid pulse.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : fetch request (ignored while busy)
//   pixel_*, scroll_*, nt_sel, pat_sel, mirror : fetch inputs, latched on start
//   mem_req/mem_addr    : VRAM read request and address
//   mem_ack/mem_rdata   : read completion and data
//   busy                : fetch in progress
//   tile_valid          : tile outputs were just updated
//   tile_idx, tile_attr, tile_pat_lo, tile_pat_hi, fine_x : tile result
module bg_tile_fetcher
  import bg_tile_fetcher_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]    NT_BASE    = ADDR_W'(NT_BASE_DEF),
  parameter logic [ADDR_W-1:0]    NT_STRIDE  = ADDR_W'(NT_STRIDE_DEF),
  parameter logic [ADDR_W-1:0]    AT_OFFSET  = ADDR_W'(AT_OFFSET_DEF),
  parameter logic [ADDR_W-1:0]    PAT_STRIDE = ADDR_W'(PAT_STRIDE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        pixel_row,
  input  logic [8:0]        pixel_col,
  input  logic [7:0]        scroll_x,
  input  logic [7:0]        scroll_y,
  input  logic [1:0]        nt_sel,
  input  logic              pat_sel,
  input  logic [1:0]        mirror,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              tile_valid,
  output logic [7:0]        tile_idx,
  output logic [1:0]        tile_attr,
  output logic [7:0]        tile_pat_lo,
  output logic [7:0]        tile_pat_hi,
  output logic [2:0]        fine_x
);

  state_e state_q, state_d;

  logic [1:0] p_w;
  logic [4:0] trow_w, tcol_w;
  logic [2:0] fx_w, fy_w;

  // Coordinates latched at start so the fetch ignores later input changes.
  logic [1:0] p_q;
  logic [4:0] trow_q, tcol_q;
  logic [2:0] fx_q, fy_q;
  logic       pat_q;

  // Bytes collected during the fetch; published together at the end.
  logic [7:0] idx_q;
  logic [1:0] attr_q;
  logic [7:0] plo_q;

  logic [7:0] tile_idx_q, tile_pat_lo_q, tile_pat_hi_q;
  logic [1:0] tile_attr_q;
  logic [2:0] fine_x_q;

  logic [ADDR_W-1:0] nt_base_p, nt_addr, at_addr, plo_addr, phi_addr;
  logic [1:0]        at_sel;
  logic              accept;
  logic              publish;

  bg_tile_fetcher_scroll_coord_wrap u_wrap (
    .pixel_row_i (pixel_row),
    .pixel_col_i (pixel_col),
    .scroll_x_i  (scroll_x),
    .scroll_y_i  (scroll_y),
    .nt_sel_i    (nt_sel),
    .mirror_i    (mirror),
    .p_o         (p_w),
    .trow_o      (trow_w),
    .tcol_o      (tcol_w),
    .fine_x_o    (fx_w),
    .fine_y_o    (fy_w)
  );

  assign accept  = (state_q == ST_IDLE) && start;
  assign publish = (state_q == ST_PHI) && mem_ack;

  assign nt_base_p = NT_BASE + (ADDR_W'(p_q) * NT_STRIDE);
  assign nt_addr   = nt_base_p + (ADDR_W'(trow_q) << 5) + ADDR_W'(tcol_q);
  assign at_addr   = nt_base_p + AT_OFFSET + (ADDR_W'(trow_q[4:2]) << 3) + ADDR_W'(tcol_q[4:2]);
  assign plo_addr  = (pat_q ? PAT_STRIDE : '0) + (ADDR_W'(idx_q) << 4) + ADDR_W'(fy_q);
  assign phi_addr  = plo_addr + ADDR_W'(8);

  // Each attribute byte covers a 4x4 tile block; the quadrant picks the pair.
  assign at_sel = {trow_q[1], tcol_q[1]};

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_NT;
      ST_NT: begin
        mem_req  = 1'b1;
        mem_addr = nt_addr;
        if (mem_ack) state_d = ST_AT;
      end
      ST_AT: begin
        mem_req  = 1'b1;
        mem_addr = at_addr;
        if (mem_ack) state_d = ST_PLO;
      end
      ST_PLO: begin
        mem_req  = 1'b1;
        mem_addr = plo_addr;
        if (mem_ack) state_d = ST_PHI;
      end
      ST_PHI: begin
        mem_req  = 1'b1;
        mem_addr = phi_addr;
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign tile_valid = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_q    <= p_w;
      trow_q <= trow_w;
      tcol_q <= tcol_w;
      fx_q   <= fx_w;
      fy_q   <= fy_w;
      pat_q  <= pat_sel;
    end
    if (state_q == ST_NT  && mem_ack) idx_q  <= mem_rdata;
    if (state_q == ST_AT  && mem_ack) attr_q <= mem_rdata[{at_sel, 1'b0} +: 2];
    if (state_q == ST_PLO && mem_ack) plo_q  <= mem_rdata;
  end

  // Outputs load on the last ack so they are valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_idx_q    <= '0;
      tile_attr_q   <= '0;
      tile_pat_lo_q <= '0;
      tile_pat_hi_q <= '0;
      fine_x_q      <= '0;
    end else if (publish) begin
      tile_idx_q    <= idx_q;
      tile_attr_q   <= attr_q;
      tile_pat_lo_q <= plo_q;
      tile_pat_hi_q <= mem_rdata;
      fine_x_q      <= fx_q;
    end
  end

  assign tile_idx    = tile_idx_q;
  assign tile_attr   = tile_attr_q;
  assign tile_pat_lo = tile_pat_lo_q;
  assign tile_pat_hi = tile_pat_hi_q;
  assign fine_x      = fine_x_q;

endmodule
